// File: rtl/rf_watch_pkg.sv
// Shared types and sizing helpers for the register-file watch checker and its trace FIFO.
package rf_watch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  function automatic int idx_width(input int num_watch);
    return (num_watch <= 2) ? 1 : $clog2(num_watch);
  endfunction

  // Trace entries are packed as {channel index, written value, cycle stamp}.
  function automatic int trace_width(input int idx_w, input int xlen, input int cnt_w);
    return idx_w + xlen + cnt_w;
  endfunction

endpackage

// File: rtl/rf_watch_checker_fifo.sv
// Synchronous FIFO for watch trace entries; a push into a full FIFO succeeds only alongside a pop.
module watch_trace_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rf_watch_checker.sv
// Watches register-file writeback for configured registers, traces watched writes and
// grades the final register values against expectations once the core halts.
module rf_watch_checker
  import rf_watch_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int NUM_WATCH      = 3,
  parameter int IDX_W          = idx_width(NUM_WATCH),
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [REG_AW-1:0] cfg_addr,
  input  logic [XLEN-1:0]   cfg_expect,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [XLEN-1:0]   rf_wdata,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [IDX_W-1:0]  tr_idx,
  output logic [XLEN-1:0]   tr_data,
  output logic [CNT_W-1:0]  tr_cycle,
  output logic              tr_ovf
);

  localparam int TR_W = trace_width(IDX_W, XLEN, CNT_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [REG_AW-1:0] cfg_addr_q [NUM_WATCH];
  logic [REG_AW-1:0] cfg_addr_d [NUM_WATCH];
  logic [XLEN-1:0]   cfg_expect_q [NUM_WATCH];
  logic [XLEN-1:0]   cfg_expect_d [NUM_WATCH];
  logic [XLEN-1:0]   last_q [NUM_WATCH];
  logic [XLEN-1:0]   last_d [NUM_WATCH];
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic              tr_ovf_q, tr_ovf_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              fail_q, fail_d, timeout_q, timeout_d;

  logic [NUM_WATCH-1:0] hit, mismatch;
  logic [IDX_W-1:0]     hit_idx, mismatch_idx;
  logic                 settled, start_go, watched;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [TR_W-1:0]      push_data, pop_data;

  // Descending scans leave the lowest matching channel in the index variables.
  always_comb begin
    hit          = '0;
    mismatch     = '0;
    hit_idx      = '0;
    mismatch_idx = '0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      hit[i]      = rf_we && (rf_waddr != '0) && (cfg_addr_q[i] == rf_waddr);
      mismatch[i] = (last_q[i] != cfg_expect_q[i]);
      if (hit[i])      hit_idx      = IDX_W'(i);
      if (mismatch[i]) mismatch_idx = IDX_W'(i);
    end
    settled   = (state_q == ST_IDLE) || (state_q == ST_PASS) ||
                (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    start_go  = start && settled;
    watched   = (state_q == ST_RUN) && (hit != '0);
    fifo_pop  = tr_ready && !fifo_empty;
    push_data = {hit_idx, rf_wdata, cycle_count_q};
  end

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    fail_idx_d    = fail_idx_q;
    tr_ovf_d      = tr_ovf_q;
    cfg_addr_d    = cfg_addr_q;
    cfg_expect_d  = cfg_expect_q;
    last_d        = last_q;

    if (settled && cfg_we && (32'(cfg_idx) < NUM_WATCH)) begin
      cfg_addr_d[cfg_idx]   = cfg_addr;
      cfg_expect_d[cfg_idx] = cfg_expect;
    end

    case (state_q)
      ST_RUN: begin
        for (int i = 0; i < NUM_WATCH; i++) begin
          if (hit[i]) last_d[i] = rf_wdata;
        end
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
        if (halt) state_d = ST_CHECK;
        else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ST_TIMEOUT;
      end
      ST_CHECK: begin
        if (mismatch != '0) begin
          state_d    = ST_FAIL;
          fail_idx_d = mismatch_idx;
        end else begin
          state_d    = ST_PASS;
        end
      end
      default: begin
        if (start_go) begin
          state_d       = ST_RUN;
          cycle_count_d = '0;
          fail_idx_d    = '0;
          tr_ovf_d      = 1'b0;
          for (int i = 0; i < NUM_WATCH; i++) last_d[i] = '0;
        end
      end
    endcase

    if (watched && fifo_full && !fifo_pop) tr_ovf_d = 1'b1;

    busy_d    = (state_d == ST_RUN);
    pass_d    = (state_d == ST_PASS);
    timeout_d = (state_d == ST_TIMEOUT);
    fail_d    = (state_d == ST_FAIL) || timeout_d;
    done_d    = pass_d || fail_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      cfg_addr_q    <= '{default: '0};
      cfg_expect_q  <= '{default: '0};
      last_q        <= '{default: '0};
      fail_idx_q    <= '0;
      tr_ovf_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_expect_q  <= cfg_expect_d;
      last_q        <= last_d;
      fail_idx_q    <= fail_idx_d;
      tr_ovf_q      <= tr_ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
    end
  end

  watch_trace_fifo #(
    .WIDTH (TR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_go),
    .push      (watched),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign pass                       = pass_q;
  assign fail                       = fail_q;
  assign timeout                    = timeout_q;
  assign fail_idx                   = fail_idx_q;
  assign cycle_count                = cycle_count_q;
  assign tr_ovf                     = tr_ovf_q;
  assign tr_valid                   = !fifo_empty;
  assign {tr_idx, tr_data, tr_cycle} = pop_data;

endmodule

// File: tb/tb_rf_watch_checker.sv
// Self-checking bench: directed scenarios plus random programs graded by a behavioural model and trace scoreboard.
module tb_rf_watch_checker;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int NW    = 3;
  localparam int IW    = 2;
  localparam int CW    = 32;
  localparam int TO    = 20;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, cfg_we, rf_we, halt, tr_ready;
  logic [IW-1:0]   cfg_idx;
  logic [RAW-1:0]  cfg_addr, rf_waddr;
  logic [XLEN-1:0] cfg_expect, rf_wdata;
  logic            busy, done, pass, fail, timeout, tr_valid, tr_ovf;
  logic [IW-1:0]   fail_idx, tr_idx;
  logic [CW-1:0]   cycle_count, tr_cycle;
  logic [XLEN-1:0] tr_data;

  rf_watch_checker #(
    .XLEN(XLEN), .REG_AW(RAW), .NUM_WATCH(NW), .IDX_W(IW), .CNT_W(CW),
    .TIMEOUT_CYCLES(TO), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_expect(cfg_expect), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .halt(halt), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_idx(fail_idx), .cycle_count(cycle_count),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_idx(tr_idx), .tr_data(tr_data),
    .tr_cycle(tr_cycle), .tr_ovf(tr_ovf)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic [CW-1:0]   cyc;
  } tr_t;
  tr_t exp_q[$];
  bit  popped = 0;

  typedef enum int {M_IDLE, M_RUN, M_CHECK, M_PASS, M_FAIL, M_TIMEOUT} mstate_t;
  mstate_t         m_state;
  logic [RAW-1:0]  m_addr [NW];
  logic [XLEN-1:0] m_exp  [NW];
  logic [XLEN-1:0] m_last [NW];
  int unsigned     m_cycle;
  int              m_fail_idx;
  bit              m_ovf;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state = M_IDLE;
    for (int i = 0; i < NW; i++) begin
      m_addr[i] = '0;
      m_exp[i]  = '0;
      m_last[i] = '0;
    end
    m_cycle    = 0;
    m_fail_idx = 0;
    m_ovf      = 0;
    exp_q.delete();
  endtask

  // Applies the rules for one clock edge to the inputs currently driven.
  task automatic modelStep();
    int  first;
    int  occ;
    tr_t e;
    first = -1;
    if (rst) begin
      modelReset();
    end else if (m_state == M_RUN) begin
      if (rf_we && rf_waddr != 0) begin
        for (int i = 0; i < NW; i++) begin
          if (m_addr[i] == rf_waddr) begin
            m_last[i] = rf_wdata;
            if (first < 0) first = i;
          end
        end
      end
      if (first >= 0) begin
        occ = exp_q.size() + (popped ? 1 : 0);
        if (occ == DEPTH && !popped) begin
          m_ovf = 1;
        end else begin
          e.idx  = IW'(first);
          e.data = rf_wdata;
          e.cyc  = CW'(m_cycle);
          exp_q.push_back(e);
        end
      end
      if (halt) m_state = M_CHECK;
      else if (m_cycle == TO - 1) m_state = M_TIMEOUT;
      m_cycle++;
    end else if (m_state == M_CHECK) begin
      m_state = M_PASS;
      for (int i = 0; i < NW; i++) begin
        if (m_last[i] != m_exp[i]) begin
          m_state    = M_FAIL;
          m_fail_idx = i;
          break;
        end
      end
    end else begin
      if (cfg_we && int'(cfg_idx) < NW) begin
        m_addr[cfg_idx] = cfg_addr;
        m_exp[cfg_idx]  = cfg_expect;
      end
      if (start) begin
        for (int i = 0; i < NW; i++) m_last[i] = '0;
        m_cycle    = 0;
        m_fail_idx = 0;
        m_ovf      = 0;
        exp_q.delete();
        m_state    = M_RUN;
      end
    end
    popped = 0;
  endtask

  task automatic checkStatus();
    logic [4:0] flags;
    flags = {m_state == M_RUN,
             m_state inside {M_PASS, M_FAIL, M_TIMEOUT},
             m_state == M_PASS,
             m_state inside {M_FAIL, M_TIMEOUT},
             m_state == M_TIMEOUT};
    checkOutput("status_flags", {busy, done, pass, fail, timeout}, flags);
    checkOutput("fail_idx", fail_idx, m_fail_idx);
    checkOutput("cycle_count", cycle_count, m_cycle);
    checkOutput("tr_ovf", tr_ovf, m_ovf);
  endtask

  // Trace scoreboard: pops the oldest expected entry whenever the consumer takes one.
  always @(negedge clk) begin
    tr_t e;
    if (exp_q.size() > 0) begin
      checkOutput("tr_valid_set", tr_valid, 1);
      if (tr_ready) begin
        e = exp_q.pop_front();
        checkOutput("tr_entry", {tr_idx, tr_data, tr_cycle}, {e.idx, e.data, e.cyc});
        popped = 1;
      end
    end else begin
      checkOutput("tr_valid_clear", tr_valid, 0);
    end
  end

  task automatic applyStimulus();
    @(negedge clk);
    #1;
    modelStep();
    @(posedge clk);
    #1;
    checkStatus();
    rst    = 1'b0;
    start  = 1'b0;
    cfg_we = 1'b0;
    rf_we  = 1'b0;
    halt   = 1'b0;
  endtask

  task automatic doCfg(input int idx, input int addr, input int value);
    cfg_we     = 1'b1;
    cfg_idx    = IW'(idx);
    cfg_addr   = RAW'(addr);
    cfg_expect = XLEN'(value);
    applyStimulus();
  endtask

  task automatic doWrite(input int addr, input int value, input bit halt_i);
    rf_we    = 1'b1;
    rf_waddr = RAW'(addr);
    rf_wdata = XLEN'(value);
    halt     = halt_i;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int len;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; rf_we = 1'b0; halt = 1'b0; tr_ready = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_expect = '0; rf_waddr = '0; rf_wdata = '0;
    modelReset();

    rst = 1'b1;
    applyStimulus();
    checkOutput("reset_flags", {busy, done, pass, fail, timeout, tr_valid, tr_ovf}, 0);
    checkOutput("reset_cycle", cycle_count, 0);

    // Straight-line ADD program that should pass.
    doCfg(0, 27, 5); doCfg(1, 28, 7); doCfg(2, 29, 12);
    start = 1'b1; applyStimulus();
    doWrite(27, 5, 0); doWrite(28, 7, 0); doWrite(29, 12, 0);
    halt = 1'b1; applyStimulus();
    checkOutput("add_done_latency1", done, 0);
    applyStimulus();
    checkOutput("add_done", {done, pass, fail}, 3'b110);
    checkOutput("add_fail_idx", fail_idx, 0);
    tr_ready = 1'b1;
    idleCycles(4);

    // Mismatch on channel 1; channel 2 never written but expects 0.
    doCfg(0, 27, 5); doCfg(1, 28, 7); doCfg(2, 30, 0);
    start = 1'b1; applyStimulus();
    doWrite(27, 5, 0); doWrite(28, 6, 0);
    halt = 1'b1; applyStimulus();
    applyStimulus();
    checkOutput("mis_flags", {fail, timeout, pass}, 3'b100);
    checkOutput("mis_fail_idx", fail_idx, 1);

    // Timeout with no halt.
    start = 1'b1; applyStimulus();
    idleCycles(TO);
    checkOutput("to_flags", {fail, timeout, done}, 3'b111);
    checkOutput("to_cycle", cycle_count, TO);
    idleCycles(3);
    checkOutput("to_frozen", cycle_count, TO);

    // Halt in the timeout cycle wins.
    start = 1'b1; applyStimulus();
    idleCycles(TO - 1);
    halt = 1'b1; applyStimulus();
    checkOutput("halt_wins_check", {busy, done, timeout}, 3'b000);
    applyStimulus();
    checkOutput("halt_wins_final", {fail, timeout}, 2'b10);

    // Trace overflow, then a push that coincides with a pop.
    doCfg(0, 5, 0); doCfg(1, 6, 0); doCfg(2, 7, 0);
    tr_ready = 1'b0;
    start = 1'b1; applyStimulus();
    for (int i = 0; i < 8; i++) doWrite(5, i + 1, 0);
    checkOutput("ovf_not_yet", tr_ovf, 0);
    doWrite(5, 9, 0); doWrite(5, 10, 0);
    checkOutput("ovf_set", tr_ovf, 1);
    tr_ready = 1'b1;
    doWrite(5, 100, 0);
    halt = 1'b1; applyStimulus();
    idleCycles(10);

    // x0 is never captured; a shared register traces once with the lower channel.
    doCfg(0, 0, 0); doCfg(1, 5, 9); doCfg(2, 5, 9);
    start = 1'b1; applyStimulus();
    doWrite(0, 3, 0);
    doWrite(5, 9, 1);
    applyStimulus();
    checkOutput("edge_pass", pass, 1);
    idleCycles(2);

    // Reset in the middle of a run; config, start and cfg writes during RUN.
    doCfg(0, 9, 4);
    start = 1'b1; applyStimulus();
    doWrite(9, 4, 0);
    doCfg(0, 9, 8);
    start = 1'b1; applyStimulus();
    checkOutput("start_in_run_ignored", cycle_count, 3);
    rst = 1'b1; applyStimulus();
    checkOutput("midrst_flags", {busy, done, pass, fail, timeout, tr_valid, tr_ovf}, 0);
    checkOutput("midrst_cycle", cycle_count, 0);
    start = 1'b1; applyStimulus();
    doWrite(9, 4, 1);
    applyStimulus();
    checkOutput("midrst_cfg_cleared", pass, 1);

    // Random programs.
    for (int it = 0; it < 150; it++) begin
      for (int c = 0; c < NW; c++) begin
        cfg_we     = 1'b1;
        cfg_idx    = IW'($urandom_range(0, 3));
        cfg_addr   = RAW'($urandom_range(0, 6));
        cfg_expect = XLEN'($urandom_range(0, 3));
        applyStimulus();
      end
      start = 1'b1; applyStimulus();
      len = $urandom_range(3, 24);
      for (int k = 0; k < len; k++) begin
        rf_we    = ($urandom_range(0, 3) != 0);
        rf_waddr = RAW'($urandom_range(0, 6));
        rf_wdata = XLEN'($urandom_range(0, 3));
        tr_ready = ($urandom_range(0, 2) == 0);
        halt     = (k == len - 1) || ($urandom_range(0, 30) == 0);
        start    = ($urandom_range(0, 20) == 0);
        if ($urandom_range(0, 15) == 0) begin
          cfg_we     = 1'b1;
          cfg_idx    = IW'($urandom_range(0, 3));
          cfg_addr   = RAW'($urandom_range(0, 6));
          cfg_expect = XLEN'($urandom_range(0, 3));
        end
        rst = ($urandom_range(0, 200) == 0);
        applyStimulus();
      end
      for (int k = 0; k < 3; k++) begin
        tr_ready = $urandom_range(0, 1) != 0;
        applyStimulus();
      end
    end

    tr_ready = 1'b1;
    idleCycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
